mux_scan_seq: RTL and testbench

Parametrised, registered N:1 channel multiplexer with a built-in select sequencer. It is the clocked successor to the 16:1 combinational mux. It operates in two modes:
- Manual: the select comes from a port.
- Auto-scan: an internal counter steps through every channel, holding each one for a programmable dwell time.

It sits between a bank of parallel data sources and a single serial consumer.

---
 rtl/mux_pkg.sv | 10 +
 rtl/mux_dwell_cnt.sv | 28 ++
 rtl/mux_scan_seq.sv | 86 ++++++++
 tb/tb_mux_scan_seq.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the scanning channel mux: mode encodings and default geometry.
package mux_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  localparam int CHANNELS_D = 16;
  localparam int SEL_W_D    = 4;
  localparam int WIDTH_D    = 1;
  localparam int DWELL_D    = 2;
endpackage

// File: rtl/mux_dwell_cnt.sv
// Dwell counter for the auto-scan sequencer: counts 0..DWELL-1 on enabled cycles
// and pulses tick on the last count.
module mux_dwell_cnt #(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic at_start
);
  localparam int CW = $clog2(DWELL) + 1;

  logic [CW-1:0] cnt_q, cur;

  // clr makes this cycle count as dwell 0, so a restarted scan holds its first
  // channel for the full dwell; with en low it simply parks the count at 0.
  assign cur      = clr ? '0 : cnt_q;
  assign tick     = en && (cur == CW'(DWELL - 1));
  assign at_start = (cur == '0);

  always_ff @(posedge clk) begin
    if (rst)       cnt_q <= '0;
    else if (en)   cnt_q <= tick ? '0 : cur + CW'(1);
    else if (clr)  cnt_q <= '0;
  end
endmodule

// File: rtl/mux_scan_seq.sv
// Registered N:1 channel mux with manual select or auto-scan sequencing;
// owns the channel pointer, wrap tracking and output registers.
module mux_scan_seq
  import mux_pkg::*;
#(
  parameter int WIDTH    = WIDTH_D,
  parameter int CHANNELS = CHANNELS_D,
  parameter int SEL_W    = SEL_W_D,
  parameter int DWELL    = DWELL_D
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          sel_out,
  output logic                      valid,
  output logic                      wrap
);
  logic [CHANNELS-1:0][WIDTH-1:0] ch;
  logic [SEL_W-1:0] chan_q, cur_chan;
  logic [WIDTH-1:0] man_d, auto_d;
  logic mode_q, wrap_pend, pend_eff, entry, in_range, last, wrap_hit;
  logic tick, at_start;

  assign ch       = data_in;
  assign entry    = (mode == MODE_AUTO) && (mode_q == MODE_MANUAL);
  assign cur_chan = entry ? '0 : chan_q;
  assign pend_eff = entry ? 1'b0 : wrap_pend;
  assign last     = (cur_chan == SEL_W'(CHANNELS - 1));
  assign in_range = ({1'b0, sel_in} < (SEL_W + 1)'(CHANNELS));
  assign wrap_hit = pend_eff && (cur_chan == '0) && at_start;

  always_comb begin
    man_d  = '0;
    auto_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sel_in == SEL_W'(c))   man_d  = ch[c];
      if (cur_chan == SEL_W'(c)) auto_d = ch[c];
    end
  end

  mux_dwell_cnt #(.DWELL(DWELL)) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .en       (en && (mode == MODE_AUTO)),
    .clr      (en && ((mode == MODE_MANUAL) || entry)),
    .tick     (tick),
    .at_start (at_start)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      sel_out   <= '0;
      valid     <= 1'b0;
      wrap      <= 1'b0;
      chan_q    <= '0;
      mode_q    <= MODE_MANUAL;
      wrap_pend <= 1'b0;
    end else if (!en) begin
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      mode_q <= mode;
      if (mode == MODE_MANUAL) begin
        y       <= in_range ? man_d : '0;
        sel_out <= sel_in;
        valid   <= in_range;
        wrap    <= 1'b0;
        chan_q  <= '0;
      end else begin
        y       <= auto_d;
        sel_out <= cur_chan;
        valid   <= 1'b1;
        wrap    <= wrap_hit;
        if (tick) chan_q <= last ? '0 : cur_chan + SEL_W'(1);
        else      chan_q <= cur_chan;
        // pending wrap survives until channel 0's first output consumes it
        wrap_pend <= (tick && last) || (pend_eff && !wrap_hit);
      end
    end
  end
endmodule

// File: tb/tb_mux_scan_seq.sv
// Scoreboard bench for mux_scan_seq: a 16-channel and a 10-channel instance on one clock.
module tb_mux_scan_seq;
  logic        clk = 1'b0;
  logic        rst, en, mode;
  logic [3:0]  sel_in;
  logic [15:0] data_in;
  logic        ya, va, wa, yb, vb, wb;
  logic [3:0]  sa, sb;

  always #5 clk = ~clk;

  mux_scan_seq #(.WIDTH(1), .CHANNELS(16), .SEL_W(4), .DWELL(2)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .data_in(data_in),
    .y(ya), .sel_out(sa), .valid(va), .wrap(wa));

  mux_scan_seq #(.WIDTH(1), .CHANNELS(10), .SEL_W(4), .DWELL(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .data_in(data_in[9:0]),
    .y(yb), .sel_out(sb), .valid(vb), .wrap(wb));

  typedef struct {
    bit       chk;
    bit       use_b;
    logic     y;
    logic [3:0] s;
    logic     v;
    logic     w;
  } exp_t;

  typedef struct {
    logic [3:0] sel;
    logic       y;
  } vec_t;

  exp_t  sbq[$];
  int    n_run = 0, n_fail = 0, step = 0;
  string phase;
  bit    man_seq[16] = '{0,1,1,0,1,1,0,1,0,1,1,0,1,1,0,1};
  vec_t  tbl[16];

  function automatic exp_t ex(bit b, logic y, logic [3:0] s, logic v, logic w);
    exp_t e;
    e.chk = 1'b1; e.use_b = b; e.y = y; e.s = s; e.v = v; e.w = w;
    return e;
  endfunction

  function automatic exp_t ea(int c, logic w);
    return ex(1'b0, man_seq[c], 4'(c), 1'b1, w);
  endfunction

  task automatic cyc(input logic r, input logic e, input logic m, input logic [3:0] s, input exp_t x);
    exp_t got;
    logic [6:0] act, req;
    rst = r; en = e; mode = m; sel_in = s;
    sbq.push_back(x);
    @(negedge clk);
    step++;
    got = sbq.pop_front();
    if (got.chk) begin
      act = got.use_b ? {yb, sb, vb, wb} : {ya, sa, va, wa};
      req = {got.y, got.s, got.v, got.w};
      n_run++;
      if (act !== req) begin
        n_fail++;
        $display("FAIL %s step %0d: y/sel/valid/wrap got %b_%h_%b_%b required %b_%h_%b_%b",
                 phase, step, act[6], act[5:2], act[1], act[0], req[6], req[5:2], req[1], req[0]);
      end
    end
  endtask

  task automatic do_reset(input logic m);
    cyc(1'b1, 1'b1, m, 4'd0, ex(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
  endtask

  // i-th output of a scan started from channel 0 with DWELL=2
  task automatic auto_from(input int i0, input int n);
    for (int i = i0; i < i0 + n; i++)
      cyc(1'b0, 1'b1, 1'b1, 4'd0, ea((i / 2) % 16, (i > 0) && (i % 32 == 0)));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].sel = 4'(i);
      tbl[i].y   = man_seq[i];
    end
    data_in = 16'hB6B6;
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel_in = '0;

    phase = "reset";
    do_reset(1'b0);

    phase = "manual_sweep";
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 1'b1, 1'b0, tbl[i].sel, ex(1'b0, tbl[i].y, tbl[i].sel, 1'b1, 1'b0));

    phase = "auto_scan";
    do_reset(1'b1);
    auto_from(0, 35);

    phase = "out_of_range";
    do_reset(1'b0);
    cyc(1'b0, 1'b1, 1'b0, 4'd12, ex(1'b1, 1'b0, 4'd12, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 4'd9,  ex(1'b1, 1'b1, 4'd9,  1'b1, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 4'd15, ex(1'b1, 1'b0, 4'd15, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 4'd12, ex(1'b0, 1'b1, 4'd12, 1'b1, 1'b0));

    phase = "enable_hold";
    do_reset(1'b1);
    auto_from(0, 11);
    for (int k = 0; k < 3; k++)
      cyc(1'b0, 1'b0, 1'b1, 4'd0, ex(1'b0, man_seq[5], 4'd5, 1'b0, 1'b0));
    cyc(1'b0, 1'b1, 1'b1, 4'd0, ea(5, 1'b0));
    cyc(1'b0, 1'b1, 1'b1, 4'd0, ea(6, 1'b0));

    phase = "mode_switch";
    cyc(1'b0, 1'b1, 1'b1, 4'd0, ea(6, 1'b0));
    cyc(1'b0, 1'b1, 1'b1, 4'd0, ea(7, 1'b0));
    cyc(1'b0, 1'b1, 1'b0, 4'd3, ex(1'b0, man_seq[3], 4'd3, 1'b1, 1'b0));
    cyc(1'b0, 1'b1, 1'b1, 4'd3, ea(0, 1'b0));
    cyc(1'b0, 1'b1, 1'b1, 4'd3, ea(0, 1'b0));
    cyc(1'b0, 1'b1, 1'b1, 4'd3, ea(1, 1'b0));
    phase = "live_data";
    data_in = 16'h0000;
    cyc(1'b0, 1'b1, 1'b1, 4'd3, ex(1'b0, 1'b0, 4'd1, 1'b1, 1'b0));
    data_in = 16'hB6B6;
    cyc(1'b0, 1'b1, 1'b1, 4'd3, ea(2, 1'b0));

    phase = "reset_mid_scan";
    do_reset(1'b1);
    auto_from(0, 19);
    cyc(1'b1, 1'b1, 1'b1, 4'd0, ex(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    auto_from(0, 3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
